fp_normalize_pack: RTL and testbench

Sequential post-add stage of the IEEE-754 single-precision adder/subtractor datapath. Accepts the raw 24-bit mantissa sum/difference, carry-out and guard/round/sticky bits from the mantissa add stage, together with the result sign and biased exponent. It normalizes the value with a one-bit-per-cycle shifter, optionally rounds to nearest-even, and packs a 32-bit IEEE word. Valid/ready handshakes are used on both sides; one operation is in flight at a time.

---
 rtl/fp_normalize_pack.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pack.sv
// Post-add normalize / round / pack stage of the binary32 adder, one operation in flight.
// Define FPNP_ROUND_EN to add the round-to-nearest-even ROUND state; otherwise the result is truncated.
module fp_normalize_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [23:0] in_mant,
    input  logic        in_cout,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

`ifdef FPNP_ROUND_EN
    localparam state_t FINISH = ROUND;
`else
    localparam state_t FINISH = DONE;
`endif

    // Returns {overflow, underflow, word}; exponents of 255 and above saturate to infinity.
    function automatic logic [33:0] pack_word(input logic s, input logic [23:0] m, input logic [8:0] e);
        logic [7:0] ef;
        if (e >= 9'd255)
            return {2'b10, s, 8'hFF, 23'd0};
        ef = m[23] ? e[7:0] : 8'd0;
        return {1'b0, (ef == 8'd0) && (m[22:0] != 23'd0), s, ef, m[22:0]};
    endfunction

    state_t      r_state, w_next;
    logic [23:0] r_mant;
    logic [8:0]  r_exp;
    logic        r_g, r_r, r_s, r_sign;
    logic [31:0] r_result;
    logic        r_overflow, r_underflow, r_zero;

    logic        w_accept;
    logic [8:0]  w_in_exp, w_cap_exp;
    logic [23:0] w_cap_mant;
    logic        w_cap_g, w_cap_r, w_cap_s;
    logic        w_cap_zero, w_cap_ovf, w_cap_done;
    logic        w_norm_ovf, w_need_shift, w_sh_done;
    logic [23:0] w_sh_mant;
    logic [8:0]  w_sh_exp;
    logic        w_load, w_load_zero, w_pk_sign;
    logic [23:0] w_pk_mant;
    logic [8:0]  w_pk_exp;

    assign w_accept = in_valid && in_ready;
    assign w_in_exp = (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};

    always_comb begin
        if (in_cout) begin
            w_cap_mant = {1'b1, in_mant[23:1]};
            w_cap_g    = in_mant[0];
            w_cap_r    = in_grs[2];
            w_cap_s    = |in_grs[1:0];
            w_cap_exp  = w_in_exp + 9'd1;
        end else begin
            w_cap_mant = in_mant;
            w_cap_g    = in_grs[2];
            w_cap_r    = in_grs[1];
            w_cap_s    = in_grs[0];
            w_cap_exp  = w_in_exp;
        end
    end

    // Normalization finishes on the edge that produces a normalized value, so the
    // "done" test looks one shift ahead instead of spending an extra idle NORM cycle.
    assign w_cap_zero   = !in_cout && (in_mant == 24'd0);
    assign w_cap_ovf    = w_cap_exp >= 9'd255;
    assign w_cap_done   = w_cap_mant[23] || (w_cap_exp <= 9'd1);
    assign w_norm_ovf   = r_exp >= 9'd255;
    assign w_need_shift = !r_mant[23] && (r_exp > 9'd1);
    assign w_sh_mant    = {r_mant[22:0], r_g};
    assign w_sh_exp     = r_exp - 9'd1;
    assign w_sh_done    = w_sh_mant[23] || (w_sh_exp <= 9'd1);

`ifdef FPNP_ROUND_EN
    logic        w_rnd_inc;
    logic [24:0] w_rnd_sum;
    logic [23:0] w_rnd_mant;
    logic [8:0]  w_rnd_exp;

    assign w_rnd_inc  = r_g && (r_r || r_s || r_mant[0]);
    assign w_rnd_sum  = {1'b0, r_mant} + {24'd0, w_rnd_inc};
    assign w_rnd_mant = w_rnd_sum[24] ? 24'h800000 : w_rnd_sum[23:0];
    assign w_rnd_exp  = r_exp + {8'd0, w_rnd_sum[24]};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_cap_zero)      w_next = DONE;
                else if (w_cap_ovf)  w_next = NORM;
                else if (w_cap_done) w_next = FINISH;
                else                 w_next = NORM;
            end
            NORM: begin
                if (w_norm_ovf)        w_next = DONE;
                else if (w_need_shift) w_next = w_sh_done ? FINISH : NORM;
                else                   w_next = FINISH;
            end
`ifdef FPNP_ROUND_EN
            ROUND: w_next = DONE;
`endif
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Selects which value gets packed into the result registers on the edge entering DONE.
    always_comb begin
        w_load      = 1'b0;
        w_load_zero = 1'b0;
        w_pk_sign   = r_sign;
        w_pk_mant   = r_mant;
        w_pk_exp    = r_exp;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_cap_zero) begin
                    w_load      = 1'b1;
                    w_load_zero = 1'b1;
                    w_pk_sign   = 1'b0;
                    w_pk_mant   = 24'd0;
                    w_pk_exp    = 9'd0;
                end
`ifndef FPNP_ROUND_EN
                else if (!w_cap_ovf && w_cap_done) begin
                    w_load    = 1'b1;
                    w_pk_sign = in_sign;
                    w_pk_mant = w_cap_mant;
                    w_pk_exp  = w_cap_exp;
                end
`endif
            end
            NORM: begin
                if (w_norm_ovf) begin
                    w_load = 1'b1;
                end
`ifndef FPNP_ROUND_EN
                else if (w_need_shift) begin
                    w_load    = w_sh_done;
                    w_pk_mant = w_sh_mant;
                    w_pk_exp  = w_sh_exp;
                end else begin
                    w_load = 1'b1;
                end
`endif
            end
`ifdef FPNP_ROUND_EN
            ROUND: begin
                w_load    = 1'b1;
                w_pk_mant = w_rnd_mant;
                w_pk_exp  = w_rnd_exp;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mant <= 24'd0;
            r_exp  <= 9'd0;
            r_g    <= 1'b0;
            r_r    <= 1'b0;
            r_s    <= 1'b0;
            r_sign <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_sign <= in_sign && !w_cap_zero;
            r_mant <= w_cap_mant;
            r_exp  <= w_cap_exp;
            r_g    <= w_cap_g;
            r_r    <= w_cap_r;
            r_s    <= w_cap_s;
        end else if (r_state == NORM && !w_norm_ovf && w_need_shift) begin
            r_mant <= w_sh_mant;
            r_exp  <= w_sh_exp;
            r_g    <= r_r;
            r_r    <= r_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_load) begin
            {r_overflow, r_underflow, r_result} <= pack_word(w_pk_sign, w_pk_mant, w_pk_exp);
            r_zero <= w_load_zero;
        end
    end

    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack; expectations follow FPNP_ROUND_EN when it is defined.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [23:0] in_mant = 24'd0;
    logic        in_cout = 1'b0;
    logic [2:0]  in_grs = 3'd0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, overflow, underflow, zero;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FPNP_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    fp_normalize_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_cout   (in_cout),
        .in_grs    (in_grs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Drives one bundle, returns edges from the handshake edge (counted as 1) to out_valid.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic c, input logic [2:0] grs, output int lat);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_cout = c; in_grs = grs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    // Flags compared as {overflow, underflow, zero}.
    task automatic run_case(input string tag, input logic s, input logic [7:0] e, input logic [23:0] m,
                            input logic c, input logic [2:0] grs, input logic [31:0] want,
                            input logic [2:0] want_flags, input int want_lat);
        int lat;
        send(s, e, m, c, grs, lat);
        check({tag, " result"}, result, want);
        check({tag, " flags"}, {29'd0, overflow, underflow, zero}, {29'd0, want_flags});
        check({tag, " latency"}, lat, want_lat);
        check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, " drained out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " drained in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, overflow, underflow, zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // out_ready high while idle must not disturb anything.
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 check("early out_ready", {31'd0, out_valid}, 32'd0);
        @(negedge clk) out_ready = 1'b0;

        run_case("one_plus_one", 1'b0, 8'd127, 24'h000000, 1'b1, 3'b000, 32'h40000000, 3'b000, ROUND_EN ? 2 : 1);
        drain("one_plus_one");
        run_case("carry_mant", 1'b0, 8'd127, 24'h800000, 1'b1, 3'b000, 32'h40400000, 3'b000, ROUND_EN ? 2 : 1);
        drain("carry_mant");
        run_case("zero", 1'b1, 8'd127, 24'h000000, 1'b0, 3'b101, 32'h00000000, 3'b001, 1);
        drain("zero");
        run_case("shift23", 1'b0, 8'd127, 24'h000001, 1'b0, 3'b000, 32'h34000000, 3'b000, ROUND_EN ? 25 : 24);
        drain("shift23");
        run_case("round_up_carry", 1'b0, 8'd127, 24'hFFFFFF, 1'b0, 3'b100,
                 ROUND_EN ? 32'h40000000 : 32'h3FFFFFFF, 3'b000, ROUND_EN ? 2 : 1);

        // Result and flags must stay put while the consumer stalls.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold result", result, ROUND_EN ? 32'h40000000 : 32'h3FFFFFFF);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
        end
        drain("round_up_carry");

        run_case("ovf_capture", 1'b0, 8'd254, 24'h800000, 1'b1, 3'b000, 32'h7F800000, 3'b100, 2);
        drain("ovf_capture");
        run_case("ovf_round", 1'b1, 8'd254, 24'hFFFFFF, 1'b0, 3'b100,
                 ROUND_EN ? 32'hFF800000 : 32'hFF7FFFFF, ROUND_EN ? 3'b100 : 3'b000, ROUND_EN ? 2 : 1);
        drain("ovf_round");
        run_case("tie_even", 1'b0, 8'd127, 24'h800002, 1'b0, 3'b100, 32'h3F800002, 3'b000, ROUND_EN ? 2 : 1);
        drain("tie_even");
        run_case("sticky_up", 1'b0, 8'd127, 24'h800002, 1'b0, 3'b101,
                 ROUND_EN ? 32'h3F800003 : 32'h3F800002, 3'b000, ROUND_EN ? 2 : 1);
        drain("sticky_up");
        run_case("cout_sticky", 1'b0, 8'd127, 24'h800001, 1'b1, 3'b001,
                 ROUND_EN ? 32'h40400001 : 32'h40400000, 3'b000, ROUND_EN ? 2 : 1);
        drain("cout_sticky");
        run_case("denormal", 1'b0, 8'd3, 24'h000100, 1'b0, 3'b000, 32'h00000400, 3'b010, ROUND_EN ? 4 : 3);
        drain("denormal");
        run_case("exp_zero", 1'b1, 8'd0, 24'h400000, 1'b0, 3'b000, 32'h80400000, 3'b010, ROUND_EN ? 2 : 1);
        drain("exp_zero");

        // Abort a long normalization with an asynchronous reset.
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd127; in_mant = 24'h000001; in_cout = 1'b0; in_grs = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 check("abort no result", {31'd0, out_valid}, 32'd0);

        run_case("after_abort", 1'b0, 8'd127, 24'h000000, 1'b1, 3'b000, 32'h40000000, 3'b000, ROUND_EN ? 2 : 1);
        drain("after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
